mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/fewcore_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore memory path: arbiter FSM states,
// requester port indices and small address helpers.
package fewcore_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RESP      = 2'd2
  } arb_state_t;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins outright, and a tie goes
// to the port that was not granted last.
module rr_arbiter2
  import fewcore_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == PORT_LOADER) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between the core and loader ports.
// Requests are issued to memory in the acceptance cycle; responses return to the owner.
module mem_arbiter
  import fewcore_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_valid,
  output logic          c_ready,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_rsp_valid,
  output logic          c_rsp_err,
  output logic [DW-1:0] c_rsp_rdata,
  input  logic          l_valid,
  output logic          l_ready,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_rsp_valid,
  output logic          l_rsp_err,
  output logic [DW-1:0] l_rsp_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    r_state;
  logic          r_last;
  logic          r_owner;
  logic          r_err;
  logic [1:0]    r_lat;

  logic [1:0]    w_grant;
  logic          w_idle;
  logic          w_acc;
  logic          w_port;
  logic          w_we;
  logic          w_aligned;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_rsp_v;
  logic          w_rsp_err;
  logic [DW-1:0] w_rsp_rdata;

  rr_arbiter2 u_rr (
    .req   ({l_valid, c_valid}),
    .last  (r_last),
    .grant (w_grant)
  );

  // Outputs are qualified with reset so everything reads 0 in the reset cycle,
  // even though the synchronous reset has not yet moved the state.
  assign w_idle    = (r_state == IDLE) && !reset;
  assign w_acc     = w_idle && (w_grant != 2'b00);
  assign w_port    = w_grant[1];
  assign w_addr    = w_port ? l_addr  : c_addr;
  assign w_wdata   = w_port ? l_wdata : c_wdata;
  assign w_we      = w_port ? l_we    : c_we;
  assign w_aligned = is_aligned(w_addr[1:0]);

  assign c_ready   = w_idle & w_grant[0];
  assign l_ready   = w_idle & w_grant[1];

  assign mem_we    = w_acc &  w_we & w_aligned;
  assign mem_re    = w_acc & ~w_we & w_aligned;
  assign mem_waddr = mem_we ? w_addr  : '0;
  assign mem_wdata = mem_we ? w_wdata : '0;
  assign mem_raddr = mem_re ? w_addr  : '0;

  always_comb begin
    w_rsp_v     = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    if (!reset) begin
      case (r_state)
        READ_WAIT: if (r_lat == 2'd0) begin
          w_rsp_v     = 1'b1;
          w_rsp_rdata = mem_rdata;
        end
        RESP: begin
          w_rsp_v   = 1'b1;
          w_rsp_err = r_err;
        end
        default: ;
      endcase
    end
  end

  assign c_rsp_valid = w_rsp_v & (r_owner == PORT_CORE);
  assign l_rsp_valid = w_rsp_v & (r_owner == PORT_LOADER);
  assign c_rsp_err   = c_rsp_valid & w_rsp_err;
  assign l_rsp_err   = l_rsp_valid & w_rsp_err;
  assign c_rsp_rdata = c_rsp_valid ? w_rsp_rdata : '0;
  assign l_rsp_rdata = l_rsp_valid ? w_rsp_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_lat   <= '0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_owner <= w_port;
          r_last  <= w_port;
          r_err   <= !w_aligned;
          if (w_aligned && !w_we) begin
            r_lat   <= 2'(MEM_LAT - 1);
            r_state <= READ_WAIT;
          end else begin
            r_state <= RESP;
          end
        end
        READ_WAIT: begin
          if (r_lat == 2'd0) r_state <= IDLE;
          else               r_lat   <= r_lat - 2'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Three arbiters (MEM_LAT 2, 1, 3) share one stimulus stream and are checked
// every cycle against a transaction-level model, plus literal scenario checks.
module tb_mem_arbiter;

  localparam int N = 3;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_valid, c_we, l_valid, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;

  logic [N-1:0] c_ready, l_ready, c_rsp_valid, c_rsp_err, l_rsp_valid, l_rsp_err;
  logic [N-1:0] mem_we, mem_re;
  logic [31:0]  c_rsp_rdata [N];
  logic [31:0]  l_rsp_rdata [N];
  logic [31:0]  mem_waddr [N];
  logic [31:0]  mem_raddr [N];
  logic [31:0]  mem_wdata [N];
  logic [31:0]  mem_rdata [N];

  int          cyc = 0;
  int          rd_cyc [N] = '{-100, -100, -100};
  logic [31:0] rd_addr [N];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .c_valid(c_valid), .c_ready(c_ready[g]), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rsp_valid(c_rsp_valid[g]), .c_rsp_err(c_rsp_err[g]), .c_rsp_rdata(c_rsp_rdata[g]),
      .l_valid(l_valid), .l_ready(l_ready[g]), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_rsp_valid(l_rsp_valid[g]), .l_rsp_err(l_rsp_err[g]), .l_rsp_rdata(l_rsp_rdata[g]),
      .mem_we(mem_we[g]), .mem_re(mem_re[g]), .mem_waddr(mem_waddr[g]), .mem_raddr(mem_raddr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    // Memory returns data only in the cycle exactly L after the read strobe.
    assign mem_rdata[g] = (cyc == rd_cyc[g] + L) ? (rd_addr[g] ^ MAGIC) : 32'hBAD0_BAD0;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: at most one transaction in flight per arbiter, responding at a due cycle.
  bit          m_busy [N];
  bit          m_last [N] = '{1'b1, 1'b1, 1'b1};
  bit          m_own  [N];
  bit          m_err  [N];
  bit          m_rd   [N];
  int          m_due  [N];
  logic [31:0] m_addr [N];
  bit          p_acc  [N];
  bit          p_done [N];
  bit          n_own  [N];
  bit          n_err  [N];
  bit          n_rd   [N];
  int          n_due  [N];
  logic [31:0] n_addr [N];

  task automatic model_check();
    for (int k = 0; k < N; k++) begin
      bit e_cr, e_lr, e_we, e_re, e_cv, e_lv, e_err, port, we;
      logic [31:0] e_rd, e_addr, e_wd, addr, wd;
      string tag;
      tag = $sformatf("L%0d", lat_of(k));
      e_cr = 0; e_lr = 0; e_we = 0; e_re = 0; e_cv = 0; e_lv = 0; e_err = 0;
      e_rd = '0; e_addr = '0; e_wd = '0;
      p_acc[k] = 0; p_done[k] = 0;
      if (!reset) begin
        if (m_busy[k]) begin
          if (cyc == m_due[k]) begin
            if (m_own[k]) e_lv = 1; else e_cv = 1;
            e_err = m_err[k];
            e_rd = m_rd[k] ? (m_addr[k] ^ MAGIC) : 32'h0;
            p_done[k] = 1;
          end
        end else if (c_valid || l_valid) begin
          port = (c_valid && l_valid) ? !m_last[k] : l_valid;
          addr = port ? l_addr : c_addr;
          we   = port ? l_we : c_we;
          wd   = port ? l_wdata : c_wdata;
          if (port) e_lr = 1; else e_cr = 1;
          p_acc[k] = 1; n_own[k] = port; n_addr[k] = addr;
          n_rd[k] = 0; n_err[k] = 0; n_due[k] = cyc + 1;
          if (addr[1:0] != 2'b00) n_err[k] = 1;
          else if (we) begin e_we = 1; e_addr = addr; e_wd = wd; end
          else begin e_re = 1; e_addr = addr; n_rd[k] = 1; n_due[k] = cyc + lat_of(k); end
        end
      end
      chk({tag, " c_ready"}, c_ready[k], e_cr);
      chk({tag, " l_ready"}, l_ready[k], e_lr);
      chk({tag, " mem_we"}, mem_we[k], e_we);
      chk({tag, " mem_re"}, mem_re[k], e_re);
      chk({tag, " c_rsp_valid"}, c_rsp_valid[k], e_cv);
      chk({tag, " l_rsp_valid"}, l_rsp_valid[k], e_lv);
      chk({tag, " c_rsp_rdata"}, c_rsp_rdata[k], e_cv ? e_rd : 32'h0);
      chk({tag, " l_rsp_rdata"}, l_rsp_rdata[k], e_lv ? e_rd : 32'h0);
      if (e_we) begin
        chk({tag, " mem_waddr"}, mem_waddr[k], e_addr);
        chk({tag, " mem_wdata"}, mem_wdata[k], e_wd);
      end
      if (e_re) chk({tag, " mem_raddr"}, mem_raddr[k], e_addr);
      if (e_cv) chk({tag, " c_rsp_err"}, c_rsp_err[k], e_err);
      if (e_lv) chk({tag, " l_rsp_err"}, l_rsp_err[k], e_err);
      if (reset) begin
        chk({tag, " rst c_rsp_err"}, c_rsp_err[k], 0);
        chk({tag, " rst l_rsp_err"}, l_rsp_err[k], 0);
        chk({tag, " rst mem_waddr"}, mem_waddr[k], 0);
        chk({tag, " rst mem_raddr"}, mem_raddr[k], 0);
        chk({tag, " rst mem_wdata"}, mem_wdata[k], 0);
      end
      if (mem_re[k]) begin
        rd_cyc[k]  = cyc;
        rd_addr[k] = mem_raddr[k];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        m_busy[k] = 0; m_last[k] = 1;
      end else if (p_done[k]) begin
        m_busy[k] = 0;
      end else if (p_acc[k]) begin
        m_busy[k] = 1; m_own[k] = n_own[k]; m_last[k] = n_own[k];
        m_err[k] = n_err[k]; m_rd[k] = n_rd[k]; m_due[k] = n_due[k]; m_addr[k] = n_addr[k];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    c_valid = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_valid = 0; l_we = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin step(); advance(); end
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    cycles(2);
    reset = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    idle_in();
    reset = 1;
    @(posedge clk); #1;

    // Reset cycle: all outputs quiet
    step();
    chk("rst c_ready", c_ready, 0);
    chk("rst l_ready", l_ready, 0);
    chk("rst rsp_valid", {c_rsp_valid, l_rsp_valid}, 0);
    advance();
    do_reset();

    // Core read, MEM_LAT=2, held request with a changed address
    c_valid = 1; c_we = 0; c_addr = 32'h10;
    step();
    chk("rd c_ready@T", c_ready[0], 1);
    chk("rd mem_re@T", mem_re[0], 1);
    chk("rd mem_raddr@T", mem_raddr[0], 32'h10);
    advance();
    c_addr = 32'h44;
    step();
    chk("rd c_ready@T+1", c_ready[0], 0);
    chk("rd rsp@T+1", c_rsp_valid[0], 0);
    advance();
    step();
    chk("rd c_ready@T+2", c_ready[0], 0);
    chk("rd rsp@T+2", c_rsp_valid[0], 1);
    chk("rd rdata@T+2", c_rsp_rdata[0], 32'hA5A5_0010);
    advance();
    idle_in();
    cycles(4);

    // Tie after reset: core, loader, core
    do_reset();
    c_valid = 1; c_we = 1; c_addr = 32'h4; c_wdata = 32'h1111_1111;
    l_valid = 1; l_we = 1; l_addr = 32'h8; l_wdata = 32'h2222_2222;
    step();
    chk("tie1 c_ready", c_ready[0], 1);
    chk("tie1 l_ready", l_ready[0], 0);
    advance();
    cycles(1);
    step();
    chk("tie2 c_ready", c_ready[0], 0);
    chk("tie2 l_ready", l_ready[0], 1);
    advance();
    cycles(1);
    step();
    chk("tie3 c_ready", c_ready[0], 1);
    chk("tie3 l_ready", l_ready[0], 0);
    advance();
    idle_in();
    cycles(3);

    // Loader write
    do_reset();
    l_valid = 1; l_we = 1; l_addr = 32'h20; l_wdata = 32'hDEAD_BEEF;
    step();
    chk("lw l_ready", l_ready[0], 1);
    chk("lw mem_we", mem_we[0], 1);
    chk("lw mem_waddr", mem_waddr[0], 32'h20);
    chk("lw mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    advance();
    l_valid = 0; l_addr = 32'h99; l_wdata = '0;
    step();
    chk("lw l_rsp_valid", l_rsp_valid[0], 1);
    chk("lw l_rsp_err", l_rsp_err[0], 0);
    chk("lw c_rsp_valid", c_rsp_valid[0], 0);
    chk("lw l_rsp_rdata", l_rsp_rdata[0], 0);
    advance();
    cycles(2);

    // Misaligned core write
    do_reset();
    c_valid = 1; c_we = 1; c_addr = 32'h13; c_wdata = 32'h1234_5678;
    step();
    chk("mis c_ready", c_ready[0], 1);
    chk("mis mem_we@T", mem_we[0], 0);
    advance();
    c_valid = 0;
    step();
    chk("mis c_rsp_valid", c_rsp_valid[0], 1);
    chk("mis c_rsp_err", c_rsp_err[0], 1);
    chk("mis mem_we@T+1", mem_we[0], 0);
    advance();
    cycles(2);

    // Reset mid-read, MEM_LAT=3
    do_reset();
    c_valid = 1; c_we = 0; c_addr = 32'h10;
    step();
    chk("rmr c_ready@T", c_ready[2], 1);
    chk("rmr mem_re@T", mem_re[2], 1);
    advance();
    c_valid = 0; reset = 1;
    step();
    chk("rmr rsp in reset", c_rsp_valid[2], 0);
    chk("rmr ready in reset", c_ready[2], 0);
    advance();
    reset = 0; c_valid = 1; c_addr = 32'h24;
    step();
    chk("rmr c_ready after reset", c_ready[2], 1);
    advance();
    c_valid = 0;
    step();
    chk("rmr no rsp@T+3", c_rsp_valid[2], 0);
    advance();
    cycles(1);
    step();
    chk("rmr new rsp", c_rsp_valid[2], 1);
    chk("rmr new rdata", c_rsp_rdata[2], 32'hA5A5_0024);
    advance();
    cycles(2);

    // Back-to-back reads, MEM_LAT=1
    do_reset();
    c_valid = 1; c_we = 0; c_addr = 32'h30;
    step();
    chk("b2b c_ready@T", c_ready[1], 1);
    advance();
    step();
    chk("b2b rsp@T+1", c_rsp_valid[1], 1);
    chk("b2b rdata@T+1", c_rsp_rdata[1], 32'hA5A5_0030);
    chk("b2b c_ready@T+1", c_ready[1], 0);
    advance();
    c_addr = 32'h34;
    step();
    chk("b2b c_ready@T+2", c_ready[1], 1);
    chk("b2b mem_raddr@T+2", mem_raddr[1], 32'h34);
    advance();
    c_valid = 0;
    step();
    chk("b2b rsp@T+3", c_rsp_valid[1], 1);
    chk("b2b rdata@T+3", c_rsp_rdata[1], 32'hA5A5_0034);
    advance();
    cycles(2);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      c_valid = ($urandom_range(0, 2) != 0);
      c_we    = 1'($urandom_range(0, 1));
      c_addr  = rand_addr();
      c_wdata = $urandom;
      l_valid = ($urandom_range(0, 2) != 0);
      l_we    = 1'($urandom_range(0, 1));
      l_addr  = rand_addr();
      l_wdata = $urandom;
      step();
      advance();
    end
    idle_in();
    reset = 0;
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
